instruction_cache: RTL

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

---
 rtl/instruction_cache_pkg.sv | 40 ++++
 rtl/icache_data_array.sv | 35 +++
 rtl/instruction_cache.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared architecture definitions plus instruction-cache types.
// Fetch address/instruction widths, the NOP encoding, FSM state encodings
// and default geometry live here so every file that imports this package
// sees one consistent set. Each macro is guarded, so a project-wide
// architecture header compiled earlier takes precedence.
// No ports: package only.

`ifndef ADDRESS_SIZE
`define ADDRESS_SIZE 10
`endif
`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 16
`endif
`ifndef NOP_INST
`define NOP_INST {`INSTRUCTION_SIZE{1'b0}}
`endif
`ifndef ICACHE_IDLE
`define ICACHE_IDLE 1'b0
`endif
`ifndef ICACHE_FILL
`define ICACHE_FILL 1'b1
`endif
`ifndef ICACHE_LINES
`define ICACHE_LINES 8
`endif
`ifndef ICACHE_WORDS
`define ICACHE_WORDS 4
`endif

package instruction_cache_pkg;

    typedef enum logic {
        ST_IDLE = `ICACHE_IDLE,
        ST_FILL = `ICACHE_FILL
    } icache_state_e;

    localparam int DEFAULT_LINES = `ICACHE_LINES;
    localparam int DEFAULT_WORDS = `ICACHE_WORDS;

endpackage

// File: rtl/icache_data_array.sv
// Word storage for the instruction cache: LINES x WORDS instructions.
// Ports:
//   clock                      write clock
//   rd_index/rd_offset/rd_data combinational read port
//   wr_en/wr_index/wr_offset/wr_data synchronous write port
// Contents are not reset; the valid bits in the top guard every read.

module icache_data_array
    import instruction_cache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int WORDS = DEFAULT_WORDS,
    parameter int WIDTH = `INSTRUCTION_SIZE
) (
    input  logic                     clock,
    input  logic [$clog2(LINES)-1:0] rd_index,
    input  logic [$clog2(WORDS)-1:0] rd_offset,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_index,
    input  logic [$clog2(WORDS)-1:0] wr_offset,
    input  logic [WIDTH-1:0]         wr_data
);

    logic [WIDTH-1:0] mem [LINES*WORDS];

    // Line-major layout: {index, offset} is the flat word address.
    assign rd_data = mem[{rd_index, rd_offset}];

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[{wr_index, wr_offset}] <= wr_data;
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with word-at-a-time refill.
// Ports:
//   clock, reset (sync, active low)
//   pc           fetch address         instruction  instruction at pc (comb)
//   flush        invalidate all lines  stall        pc not served (comb)
//   mem_req/mem_addr  refill request   mem_ack/mem_data  refill response
//   miss_count   saturating count of refills started

module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int WORDS = DEFAULT_WORDS
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [`ADDRESS_SIZE-1:0]     pc,
    input  logic                         flush,
    output logic [`INSTRUCTION_SIZE-1:0] instruction,
    output logic                         stall,
    output logic                         mem_req,
    output logic [`ADDRESS_SIZE-1:0]     mem_addr,
    input  logic                         mem_ack,
    input  logic [`INSTRUCTION_SIZE-1:0] mem_data,
    output logic [15:0]                  miss_count
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = `ADDRESS_SIZE - OFF_W - IDX_W;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;

    assign pc_off = pc[OFF_W-1:0];
    assign pc_idx = pc[OFF_W +: IDX_W];
    assign pc_tag = pc[`ADDRESS_SIZE-1 -: TAG_W];

    icache_state_e state, state_next;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [OFF_W-1:0] counter;
    logic             flush_pending;
    logic [15:0]      miss_cnt;

    logic                         hit;
    logic                         start_fill;
    logic                         fill_ack;
    logic                         last_ack;
    logic [`INSTRUCTION_SIZE-1:0] rd_data;

    // A hit is only possible in IDLE, so a line being refilled never serves
    // partially written data even if pc points back at it.
    assign hit        = reset && (state == ST_IDLE) && valid[pc_idx] && (tags[pc_idx] == pc_tag);
    assign start_fill = reset && (state == ST_IDLE) && !hit && !flush;
    assign fill_ack   = reset && (state == ST_FILL) && mem_ack;
    assign last_ack   = fill_ack && (&counter);

    assign miss_count = miss_cnt;

    icache_data_array #(
        .LINES (LINES),
        .WORDS (WORDS),
        .WIDTH (`INSTRUCTION_SIZE)
    ) u_data (
        .clock     (clock),
        .rd_index  (pc_idx),
        .rd_offset (pc_off),
        .rd_data   (rd_data),
        .wr_en     (fill_ack),
        .wr_index  (fill_idx),
        .wr_offset (counter),
        .wr_data   (mem_data)
    );

    // Next state and outputs
    always_comb begin
        state_next  = state;
        instruction = `NOP_INST;
        stall       = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        if (reset) begin
            stall = !hit;
            if (hit)
                instruction = rd_data;
            case (state)
                ST_IDLE: if (start_fill) state_next = ST_FILL;
                ST_FILL: begin
                    mem_req  = 1'b1;
                    mem_addr = {fill_tag, fill_idx, counter};
                    if (last_ack) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= ST_IDLE;
            valid         <= '0;
            counter       <= '0;
            flush_pending <= 1'b0;
            miss_cnt      <= '0;
        end else begin
            state <= state_next;

            if (state == ST_IDLE && flush)
                valid <= '0;

            if (start_fill) begin
                fill_tag       <= pc_tag;
                fill_idx       <= pc_idx;
                counter        <= '0;
                valid[pc_idx]  <= 1'b0;   // victim goes invalid immediately
                if (miss_cnt != 16'hFFFF)
                    miss_cnt <= miss_cnt + 16'd1;
            end

            if (state == ST_FILL && flush)
                flush_pending <= 1'b1;

            if (fill_ack)
                counter <= counter + 1'b1;

            // A flush seen any time during the fill (including on the final
            // ack) wipes everything, the just-filled line included.
            if (last_ack) begin
                if (flush_pending || flush)
                    valid <= '0;
                else
                    valid[fill_idx] <= 1'b1;
                flush_pending <= 1'b0;
            end
        end
    end

    // Tag storage is not reset; valid bits qualify it.
    always_ff @(posedge clock) begin
        if (last_ack)
            tags[fill_idx] <= fill_tag;
    end

endmodule
